// File: rtl/pc_fetch_pkg.sv
// rtl/pc_fetch_pkg.sv - shared encodings and constants for the instruction fetch stage
package pc_fetch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_REQ  = 2'b01,
      ST_HOLD = 2'b10
   } fetch_state_t;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
   localparam logic [31:0] WORD_ALIGN_MASK  = 32'hFFFF_FFFC;

endpackage

// File: rtl/pc_fetch.sv
// rtl/pc_fetch.sv - PC register, +4 adder, fetch FSM and accepted-instruction counter
module pc_fetch
   import pc_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] next_pc,
   input  logic        stall,
   input  logic        flush,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc_plus4,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_instr,
   output logic        misalign_err,
   output logic [31:0] fetch_cnt
);

   fetch_state_t state, state_nxt;
   logic [31:0]  pc;
   logic         pc_load;
   logic         cnt_inc;
   logic         bundle_load;

   always_comb begin
      state_nxt   = state;
      pc_load     = 1'b0;
      cnt_inc     = 1'b0;
      bundle_load = 1'b0;
      case (state)
         ST_IDLE: state_nxt = ST_REQ;
         ST_REQ: begin
            if (imem_ack) begin
               bundle_load = 1'b1;
               state_nxt   = ST_HOLD;
            end
         end
         ST_HOLD: begin
            // flush wins over stall and redirects without counting the discarded word
            if (flush) begin
               pc_load   = 1'b1;
               state_nxt = ST_REQ;
            end else if (!stall) begin
               pc_load   = 1'b1;
               cnt_inc   = 1'b1;
               state_nxt = ST_REQ;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         pc           <= RESET_PC;
         if_pc        <= 32'd0;
         if_instr     <= 32'd0;
         fetch_cnt    <= 32'd0;
         misalign_err <= 1'b0;
      end else begin
         state        <= state_nxt;
         misalign_err <= pc_load && (next_pc[1:0] != 2'b00);
         if (pc_load)
            pc <= next_pc & WORD_ALIGN_MASK;
         if (cnt_inc)
            fetch_cnt <= fetch_cnt + 32'd1;
         if (bundle_load) begin
            if_pc    <= pc;
            if_instr <= imem_rdata;
         end
      end
   end

   // decoded straight from state so an async reset drops the request at once
   assign imem_req  = (state == ST_REQ);
   assign if_valid  = (state == ST_HOLD);
   assign imem_addr = pc;
   assign pc_plus4  = pc + 32'd4;

endmodule

// File: tb/tb_pc_fetch.sv
// tb/tb_pc_fetch.sv - directed-vector bench for pc_fetch
module tb_pc_fetch;

   logic        clk;
   logic        rst_n;
   logic [31:0] next_pc;
   logic        stall;
   logic        flush;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] pc_plus4;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        misalign_err;
   logic [31:0] fetch_cnt;

   int tests_run;
   int tests_failed;

   pc_fetch dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .next_pc      (next_pc),
      .stall        (stall),
      .flush        (flush),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ack     (imem_ack),
      .imem_rdata   (imem_rdata),
      .pc_plus4     (pc_plus4),
      .if_valid     (if_valid),
      .if_pc        (if_pc),
      .if_instr     (if_instr),
      .misalign_err (misalign_err),
      .fetch_cnt    (fetch_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
      end
   endtask

   // present an ack in REQ for one cycle; returns at the negedge after it, in HOLD
   task automatic ack_word(input logic [31:0] word);
      imem_ack   = 1'b1;
      imem_rdata = word;
      @(negedge clk);
      imem_ack   = 1'b0;
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst_n      = 1'b0;
      next_pc    = 32'd0;
      stall      = 1'b0;
      flush      = 1'b0;
      imem_ack   = 1'b0;
      imem_rdata = 32'd0;

      // reset state
      @(negedge clk);
      @(negedge clk);
      check_eq("rst_req",      {31'd0, imem_req},     32'd0);
      check_eq("rst_valid",    {31'd0, if_valid},     32'd0);
      check_eq("rst_misalign", {31'd0, misalign_err}, 32'd0);
      check_eq("rst_if_pc",    if_pc,                 32'd0);
      check_eq("rst_if_instr", if_instr,              32'd0);
      check_eq("rst_cnt",      fetch_cnt,             32'd0);
      check_eq("rst_addr",     imem_addr,             32'h0000_3000);
      check_eq("rst_plus4",    pc_plus4,              32'h0000_3004);

      // release: first cycle IDLE, second REQ
      rst_n = 1'b1;
      #1;
      check_eq("idle_req", {31'd0, imem_req}, 32'd0);
      @(negedge clk);
      check_eq("req_req",   {31'd0, imem_req}, 32'd1);
      check_eq("req_addr",  imem_addr,         32'h0000_3000);
      check_eq("req_plus4", pc_plus4,          32'h0000_3004);

      // two wait cycles, request held stable; flush in REQ ignored
      flush = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check_eq("wait_req",  {31'd0, imem_req}, 32'd1);
         check_eq("wait_addr", imem_addr,         32'h0000_3000);
      end
      flush = 1'b0;

      // straight-line fetch
      next_pc = 32'h0000_3004;
      ack_word(32'h2008_0005);
      check_eq("f1_valid", {31'd0, if_valid}, 32'd1);
      check_eq("f1_req",   {31'd0, imem_req}, 32'd0);
      check_eq("f1_if_pc", if_pc,             32'h0000_3000);
      check_eq("f1_instr", if_instr,          32'h2008_0005);
      @(negedge clk);
      check_eq("f1_next_valid", {31'd0, if_valid}, 32'd0);
      check_eq("f1_next_addr",  imem_addr,         32'h0000_3004);
      check_eq("f1_cnt",        fetch_cnt,         32'd1);
      check_eq("f1_retain",     if_instr,          32'h2008_0005);

      // stall for 3 HOLD cycles, with a stray ack that must be ignored
      ack_word(32'h1111_2222);
      stall   = 1'b1;
      next_pc = 32'h0000_3008;
      imem_ack   = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq("st_valid", {31'd0, if_valid}, 32'd1);
         check_eq("st_req",   {31'd0, imem_req}, 32'd0);
         check_eq("st_instr", if_instr,          32'h1111_2222);
         check_eq("st_if_pc", if_pc,             32'h0000_3004);
         check_eq("st_addr",  imem_addr,         32'h0000_3004);
         check_eq("st_cnt",   fetch_cnt,         32'd1);
      end
      imem_ack = 1'b0;
      stall    = 1'b0;
      @(negedge clk);
      check_eq("st_rel_addr", imem_addr, 32'h0000_3008);
      check_eq("st_rel_cnt",  fetch_cnt, 32'd2);

      // flush together with stall
      ack_word(32'h3333_4444);
      flush   = 1'b1;
      stall   = 1'b1;
      next_pc = 32'h0000_3100;
      @(negedge clk);
      flush = 1'b0;
      stall = 1'b0;
      check_eq("fl_req",  {31'd0, imem_req}, 32'd1);
      check_eq("fl_addr", imem_addr,         32'h0000_3100);
      check_eq("fl_cnt",  fetch_cnt,         32'd2);

      // misaligned redirect
      ack_word(32'h5555_6666);
      next_pc = 32'h0000_3102;
      @(negedge clk);
      check_eq("ma_addr",  imem_addr,             32'h0000_3100);
      check_eq("ma_pulse", {31'd0, misalign_err}, 32'd1);
      check_eq("ma_cnt",   fetch_cnt,             32'd3);
      @(negedge clk);
      check_eq("ma_clear", {31'd0, misalign_err}, 32'd0);

      // pc_plus4 wraps at the top of the address space
      ack_word(32'h7777_8888);
      next_pc = 32'hFFFF_FFFC;
      @(negedge clk);
      check_eq("wr_addr",  imem_addr, 32'hFFFF_FFFC);
      check_eq("wr_plus4", pc_plus4,  32'h0000_0000);
      check_eq("wr_cnt",   fetch_cnt, 32'd4);

      // reset in the middle of an outstanding request
      check_eq("mr_pre_req", {31'd0, imem_req}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("mr_req",  {31'd0, imem_req}, 32'd0);
      check_eq("mr_addr", imem_addr,         32'h0000_3000);
      check_eq("mr_cnt",  fetch_cnt,         32'd0);
      @(negedge clk);
      rst_n      = 1'b1;
      imem_ack   = 1'b1;
      imem_rdata = 32'hCAFE_F00D;
      @(negedge clk);
      imem_ack = 1'b0;
      check_eq("mr_refetch_req",  {31'd0, imem_req}, 32'd1);
      check_eq("mr_refetch_addr", imem_addr,         32'h0000_3000);
      check_eq("mr_valid",        {31'd0, if_valid}, 32'd0);
      check_eq("mr_instr",        if_instr,          32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
